key_debounce: RTL and testbench



---
 rtl/key_pkg.sv | 28 ++
 rtl/key_debounce_ch.sv | 112 +++++++++++
 rtl/key_debounce.sv | 43 ++++
 tb/tb_key_debounce.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key_debounce block:
//   - clog2()               : ceiling log2, used to size the debounce counter
//   - state_e               : debounce FSM encoding (ST_STABLE / ST_PENDING)
//   - DEBOUNCE_CYCLES_50MHZ : 20 ms settle time at the 50 MHz board oscillator
// -----------------------------------------------------------------------------
package key_pkg;

    // 20 ms at 50 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_50MHZ = 1_000_000;

    typedef enum logic {
        ST_STABLE  = 1'b0,  // synchronized level agrees with key_out
        ST_PENDING = 1'b1   // synchronized level differs, counting
    } state_e;

    // Ceiling log2 for elaboration-time sizing; clog2(8) = 3, clog2(9) = 4.
    function automatic int clog2(input longint unsigned value);
        int result;
        result = 0;
        for (longint unsigned v = value - 1; v != 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage : key_pkg

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One debounce channel: 2-flop synchronizer, STABLE/PENDING FSM with a
// consecutive-cycle counter, registered level and registered edge pulses.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   key_in    in   raw pad level, asynchronous to clk
//   key_out   out  debounced level
//   key_rise  out  one-cycle pulse when key_out goes 0->1
//   key_fall  out  one-cycle pulse when key_out goes 1->0
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter logic        IDLE_LEVEL      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_out,
    output logic key_rise,
    output logic key_fall
);

    localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24)) begin : g_bad_param
        $error("key_debounce_ch: DEBOUNCE_CYCLES out of range 2..2^24");
    end

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned; that is what keeps this block free of latches.
    always_comb begin
        s1_d    = key_in;
        s2_d    = s1_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = cnt_q;
        state_d = state_q;

        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (s2_q != out_q) begin
                    // The edge that detects the mismatch is the first counted
                    // cycle, so the count restarts at 1 rather than 0. This
                    // places the accept on the (DEBOUNCE_CYCLES+2)-th edge
                    // after the pad change.
                    state_d = ST_PENDING;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_PENDING: begin
                if (s2_q == out_q) begin
                    // Bounced back: no partial credit.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    out_d   = s2_q;
                    rise_d  = s2_q;
                    fall_d  = ~s2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, as real hardware does.
    // The synchronizer flops are reset as well so a mid-PENDING reset cannot
    // leave a stale sample in the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= IDLE_LEVEL;
            s2_q    <= IDLE_LEVEL;
            out_q   <= IDLE_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_STABLE;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign key_out  = out_q;
    assign key_rise = rise_q;
    assign key_fall = fall_q;

endmodule : key_debounce_ch

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// N-channel debouncer and edge detector for Basys2 buttons/switches. Each
// channel is an independent key_debounce_ch; outputs are concatenated.
//
// Ports:
//   clk       in   system clock (50 MHz)
//   rst_n     in   asynchronous active-low reset
//   key_in    in   [N-1:0] raw pad levels, asynchronous to clk
//   key_out   out  [N-1:0] debounced levels
//   key_rise  out  [N-1:0] one-cycle rise pulses
//   key_fall  out  [N-1:0] one-cycle fall pulses
// -----------------------------------------------------------------------------
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter logic        IDLE_LEVEL      = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] key_in,
    output logic [N-1:0] key_out,
    output logic [N-1:0] key_rise,
    output logic [N-1:0] key_fall
);

    for (genvar g = 0; g < int'(N); g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .key_in   (key_in[g]),
            .key_out  (key_out[g]),
            .key_rise (key_rise[g]),
            .key_fall (key_fall[g])
        );
    end

endmodule : key_debounce

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
// Self-checking bench for key_debounce (N=4, DEBOUNCE_CYCLES=8, IDLE_LEVEL=0).
// A reference model states the rule directly: key_out[i] takes the
// synchronized level once that level has disagreed with key_out[i] on
// DEBOUNCE_CYCLES consecutive edges, and the pulse marks that edge.
// -----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int N  = 4;
    localparam int DC = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] key_in = '1;
    logic [N-1:0] key_out, key_rise, key_fall;

    int checks = 0;
    int errors = 0;

    key_debounce #(
        .N               (N),
        .DEBOUNCE_CYCLES (DC),
        .IDLE_LEVEL      (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .key_out  (key_out),
        .key_rise (key_rise),
        .key_fall (key_fall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_outs(input string name, input logic [N-1:0] o,
                               input logic [N-1:0] r, input logic [N-1:0] f);
        check({name, ".out"},  key_out,  o);
        check({name, ".rise"}, key_rise, r);
        check({name, ".fall"}, key_fall, f);
    endtask

    // Advance n rising edges, then settle 1 time unit before sampling/driving.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [N-1:0] s1, s2, out, rise, fall;
        int           run [N];  // consecutive edges with synchronized != out
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.s1 = '0; m.s2 = '0; m.out = '0; m.rise = '0; m.fall = '0;
        for (int i = 0; i < N; i++) m.run[i] = 0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input logic [N-1:0] k);
        model_t n;
        n = m;
        n.rise = '0;
        n.fall = '0;
        for (int i = 0; i < N; i++) begin
            if (m.s2[i] != m.out[i]) begin
                n.run[i] = m.run[i] + 1;
                if (n.run[i] == DC) begin
                    n.out[i]  = m.s2[i];
                    n.rise[i] = m.s2[i];
                    n.fall[i] = ~m.s2[i];
                    n.run[i]  = 0;
                end
            end else begin
                n.run[i] = 0;
            end
        end
        n.s1 = k;
        n.s2 = m.s1;
        return n;
    endfunction

    model_t mdl = model_reset();
    bit     cmp_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl <= model_reset();
        else        mdl <= model_step(mdl, key_in);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model.out",  key_out,  mdl.out);
            check("model.rise", key_rise, mdl.rise);
            check("model.fall", key_fall, mdl.fall);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] key;
        int           hold;
        logic [N-1:0] out, rise, fall;
    } vec_t;

    vec_t vecs [11];
    int   hold_left [N];

    initial begin
        // Clean press/release on channel 1, then channels 0 and 3 together.
        vecs[0]  = '{4'h2,  9, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{4'h2,  1, 4'h2, 4'h2, 4'h0};
        vecs[2]  = '{4'h2,  1, 4'h2, 4'h0, 4'h0};
        vecs[3]  = '{4'h0,  9, 4'h2, 4'h0, 4'h0};
        vecs[4]  = '{4'h0,  1, 4'h0, 4'h0, 4'h2};
        vecs[5]  = '{4'h0,  1, 4'h0, 4'h0, 4'h0};
        vecs[6]  = '{4'h9,  9, 4'h0, 4'h0, 4'h0};
        vecs[7]  = '{4'h9,  1, 4'h9, 4'h9, 4'h0};
        vecs[8]  = '{4'h9,  1, 4'h9, 4'h0, 4'h0};
        vecs[9]  = '{4'h0, 10, 4'h0, 4'h0, 4'h9};
        vecs[10] = '{4'h0,  1, 4'h0, 4'h0, 4'h0};

        // Reset with all pads pressed.
        key_in = 4'hF;
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        tick(3);
        expect_outs("in_reset", 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;
        tick(9);
        expect_outs("post_rst_e9", 4'h0, 4'h0, 4'h0);
        tick(1);
        expect_outs("post_rst_e10", 4'hF, 4'hF, 4'h0);
        tick(1);
        expect_outs("post_rst_e11", 4'hF, 4'h0, 4'h0);

        // Release everything.
        key_in = 4'h0;
        tick(9);
        expect_outs("release_all_e9", 4'hF, 4'h0, 4'h0);
        tick(1);
        expect_outs("release_all_e10", 4'h0, 4'h0, 4'hF);
        tick(1);
        expect_outs("release_all_e11", 4'h0, 4'h0, 4'h0);

        // Table-driven vectors.
        for (int v = 0; v < 11; v++) begin
            key_in = vecs[v].key;
            tick(vecs[v].hold);
            expect_outs($sformatf("vec%0d", v), vecs[v].out, vecs[v].rise, vecs[v].fall);
        end

        // Bounce on channel 2: 3-cycle segments, then hold high.
        for (int seg = 0; seg < 14; seg++) begin
            key_in[2] = (seg % 2 == 0);
            for (int c = 0; c < 3; c++) begin
                tick(1);
                expect_outs("bounce", 4'h0, 4'h0, 4'h0);
            end
        end
        key_in[2] = 1'b1;
        tick(9);
        expect_outs("bounce_settle_e9", 4'h0, 4'h0, 4'h0);
        tick(1);
        expect_outs("bounce_settle_e10", 4'h4, 4'h4, 4'h0);
        key_in = 4'h0;
        tick(10);
        expect_outs("bounce_release", 4'h0, 4'h0, 4'h4);

        // Boundary on channel 3: 7 cycles rejected, 8 cycles accepted.
        key_in = 4'h8;
        tick(7);
        key_in = 4'h0;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            expect_outs("short7", 4'h0, 4'h0, 4'h0);
        end
        key_in = 4'h8;
        tick(8);
        key_in = 4'h0;
        tick(1);
        expect_outs("exact8_e9", 4'h0, 4'h0, 4'h0);
        tick(1);
        expect_outs("exact8_e10", 4'h8, 4'h8, 4'h0);
        tick(7);
        expect_outs("exact8_hold", 4'h8, 4'h0, 4'h0);
        tick(1);
        expect_outs("exact8_fall", 4'h0, 4'h0, 4'h8);

        // Mid-PENDING reset: channel 3 settled high, channel 0 at count 5.
        key_in = 4'h8;
        tick(10);
        expect_outs("pre_rst_ch3", 4'h8, 4'h8, 4'h0);
        key_in = 4'h9;
        tick(7);
        rst_n = 1'b0;
        #1;
        expect_outs("mid_rst", 4'h0, 4'h0, 4'h0);
        tick(2);
        rst_n = 1'b1;
        tick(9);
        expect_outs("restart_e9", 4'h0, 4'h0, 4'h0);
        tick(1);
        expect_outs("restart_e10", 4'h9, 4'h9, 4'h0);
        key_in = 4'h0;
        tick(12);
        expect_outs("restart_release", 4'h0, 4'h0, 4'h0);

        // Randomized per-channel hold times, with one reset in the middle.
        for (int i = 0; i < N; i++) hold_left[i] = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (hold_left[i] == 0) begin
                    key_in[i]    = 1'($urandom_range(0, 1));
                    hold_left[i] = int'($urandom_range(1, 24));
                end
                hold_left[i]--;
            end
            if (cyc == 1000) rst_n = 1'b0;
            if (cyc == 1002) rst_n = 1'b1;
            tick(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_key_debounce
